// File: rtl/mac_rr_sched.sv
// Round-robin multiply-accumulate over three show-ahead FIFOs, one burst of up to BURST_MAX words per grant.
// First pop 1 cycle after grant; result held in OUT until i_ready, no pops while a result waits.
module mac_rr_sched #(
  parameter int DW        = 8,
  parameter int BURST_MAX = 4,
  parameter int ACC_W     = 2*DW+3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_empty,
  input  logic [DW-1:0]    i_rdata0,
  input  logic [DW-1:0]    i_rdata1,
  input  logic [DW-1:0]    i_rdata2,
  output logic [2:0]       o_ren,
  input  logic [DW-1:0]    i_coef0,
  input  logic [DW-1:0]    i_coef1,
  input  logic [DW-1:0]    i_coef2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_data,
  output logic [1:0]       o_src,
  output logic [2:0]       o_len,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  localparam logic [2:0] BMAX = 3'(BURST_MAX);

  state_t            state;
  logic [1:0]        src_q;
  logic [1:0]        last_q;
  logic [DW-1:0]     coef_q;
  logic [ACC_W-1:0]  acc;
  logic [2:0]        cnt;

  logic [1:0]        cand0, cand1, cand2;
  logic [1:0]        grant_src;
  logic              grant_vld;
  logic [DW-1:0]     grant_coef;
  logic [DW-1:0]     rdata_sel;
  logic              src_empty;
  logic              ren_now;
  logic [2*DW-1:0]   prod;

  function automatic logic [1:0] nxt(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [DW-1:0] c);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  // Search starts one past the last-served source so every source gets a turn.
  always_comb begin
    cand0     = nxt(last_q);
    cand1     = nxt(cand0);
    cand2     = last_q;
    grant_vld = |(~i_empty);
    grant_src = cand2;
    if (!i_empty[cand0])      grant_src = cand0;
    else if (!i_empty[cand1]) grant_src = cand1;
  end

  always_comb begin
    grant_coef = pick(grant_src, i_coef0, i_coef1, i_coef2);
    rdata_sel  = pick(src_q, i_rdata0, i_rdata1, i_rdata2);
    src_empty  = i_empty[src_q];
    ren_now    = (state == READ) && !src_empty && (cnt < BMAX);
    prod       = (2*DW)'(rdata_sel) * (2*DW)'(coef_q);
    o_ren        = 3'b000;
    o_ren[src_q] = ren_now;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      src_q  <= 2'd0;
      last_q <= 2'd2;
      coef_q <= '0;
      acc    <= '0;
      cnt    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            src_q  <= grant_src;
            coef_q <= grant_coef;
            acc    <= '0;
            cnt    <= 3'd0;
            state  <= READ;
          end
        end
        READ: begin
          if (ren_now) begin
            acc <= acc + ACC_W'(prod);
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 == BMAX) state <= OUT;
          end else begin
            // Source ran dry: an empty grant is dropped without moving the pointer.
            state <= (cnt == 3'd0) ? IDLE : OUT;
          end
        end
        OUT: begin
          if (i_ready) begin
            last_q <= src_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_valid = (state == OUT);
  assign o_busy  = (state != IDLE);
  assign o_data  = acc;
  assign o_src   = src_q;
  assign o_len   = cnt;

endmodule

// File: tb/tb_mac_rr_sched.sv
// Directed bench for mac_rr_sched: behavioural show-ahead FIFOs feed the DUT, accepted results are logged.
module tb_mac_rr_sched;
  localparam int DW = 8, BURST_MAX = 4, ACC_W = 2*DW+3;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [2:0]       i_empty;
  logic [DW-1:0]    i_rdata0, i_rdata1, i_rdata2;
  logic [2:0]       o_ren;
  logic [DW-1:0]    i_coef0, i_coef1, i_coef2;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_data;
  logic [1:0]       o_src;
  logic [2:0]       o_len;
  logic             o_busy;

  int tests = 0;
  int fails = 0;

  mac_rr_sched #(.DW(DW), .BURST_MAX(BURST_MAX), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_empty(i_empty),
    .i_rdata0(i_rdata0), .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
    .o_ren(o_ren), .i_coef0(i_coef0), .i_coef1(i_coef1), .i_coef2(i_coef2),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_src(o_src),
    .o_len(o_len), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Show-ahead FIFO model: pushes from the stimulus, pops on o_ren.
  logic [7:0] fmem [3][256];
  logic [7:0] rd_ptr [3] = '{8'd0, 8'd0, 8'd0};
  logic [7:0] wr_ptr [3] = '{8'd0, 8'd0, 8'd0};

  assign i_empty  = {rd_ptr[2] == wr_ptr[2], rd_ptr[1] == wr_ptr[1], rd_ptr[0] == wr_ptr[0]};
  assign i_rdata0 = fmem[0][rd_ptr[0]];
  assign i_rdata1 = fmem[1][rd_ptr[1]];
  assign i_rdata2 = fmem[2][rd_ptr[2]];

  always @(posedge i_clk) begin
    for (int n = 0; n < 3; n++)
      if (o_ren[n]) rd_ptr[n] <= rd_ptr[n] + 8'd1;
  end

  int               res_n = 0;
  int               ren_bad = 0;
  logic [ACC_W-1:0] res_data [64];
  logic [1:0]       res_src  [64];
  logic [2:0]       res_len  [64];

  always @(posedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      res_data[res_n] <= o_data;
      res_src[res_n]  <= o_src;
      res_len[res_n]  <= o_len;
      res_n           <= res_n + 1;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst && (($countones(o_ren) > 1) || (o_ren != 3'b000 && (o_valid || !o_busy))))
      ren_bad <= ren_bad + 1;
  end

  task automatic push(input int n, input logic [7:0] w);
    fmem[n][wr_ptr[n]] = w;
    wr_ptr[n] = wr_ptr[n] + 8'd1;
  endtask

  task automatic wait_res(input int target, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (res_n >= target) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_ready = 1'b1;
    i_coef0 = '0; i_coef1 = '0; i_coef2 = '0;
    repeat (2) @(negedge i_clk);
    tests++; if (o_ren !== 3'b000) begin fails++; $display("FAIL reset_ren got=%b exp=000", o_ren); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    tests++; if (o_data !== '0) begin fails++; $display("FAIL reset_data got=%0d exp=0", o_data); end
    tests++; if (o_src !== 2'd0) begin fails++; $display("FAIL reset_src got=%0d exp=0", o_src); end
    tests++; if (o_len !== 3'd0) begin fails++; $display("FAIL reset_len got=%0d exp=0", o_len); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_round_robin();
    int base;
    bit to;
    int exp;
    int s, h;
    i_coef0 = 8'd1; i_coef1 = 8'd2; i_coef2 = 8'd3;
    i_ready = 1'b1;
    base = res_n;
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < 8; k++) push(n, 8'(n*20 + k + 1));
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b001 || o_busy !== 1'b1)
      begin fails++; $display("FAIL rr_first_pop ren=%b busy=%b exp ren=001 busy=1", o_ren, o_busy); end
    repeat (3) @(negedge i_clk);
    tests++; if (o_ren !== 3'b001 || o_valid !== 1'b0)
      begin fails++; $display("FAIL rr_fourth_pop ren=%b valid=%b exp ren=001 valid=0", o_ren, o_valid); end
    @(negedge i_clk);
    tests++; if (o_valid !== 1'b1 || o_ren !== 3'b000 || o_len !== 3'd4)
      begin fails++; $display("FAIL rr_valid_latency valid=%b ren=%b len=%0d exp 1/000/4", o_valid, o_ren, o_len); end
    wait_res(base + 6, to);
    tests++; if (to) begin fails++; $display("FAIL rr_timeout got=%0d results exp=6", res_n - base); end
    for (int r = 0; r < 6; r++) begin
      s = r % 3;
      h = r / 3;
      exp = 0;
      for (int k = h*4; k < h*4 + 4; k++) exp += (s*20 + k + 1) * (s + 1);
      tests++;
      if (res_src[base+r] !== 2'(s) || res_len[base+r] !== 3'd4 || res_data[base+r] !== ACC_W'(exp)) begin
        fails++;
        $display("FAIL rr_result%0d got src=%0d len=%0d data=%0d exp src=%0d len=4 data=%0d",
                 r, res_src[base+r], res_len[base+r], res_data[base+r], s, exp);
      end
    end
    tests++; if (i_empty !== 3'b111) begin fails++; $display("FAIL rr_drained got empty=%b exp=111", i_empty); end
  endtask

  task automatic test_single();
    i_ready = 1'b0;
    i_coef1 = 8'd5;
    push(1, 8'd10);
    push(1, 8'd20);
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b010) begin fails++; $display("FAIL single_pop1 got=%b exp=010", o_ren); end
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b010) begin fails++; $display("FAIL single_pop2 got=%b exp=010", o_ren); end
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b000 || o_valid !== 1'b0)
      begin fails++; $display("FAIL single_dry ren=%b valid=%b exp 000/0", o_ren, o_valid); end
    @(negedge i_clk);
    tests++;
    if (o_valid !== 1'b1 || o_data !== ACC_W'(150) || o_src !== 2'd1 || o_len !== 3'd2) begin
      fails++;
      $display("FAIL single_result valid=%b data=%0d src=%0d len=%0d exp 1/150/1/2", o_valid, o_data, o_src, o_len);
    end
  endtask

  task automatic test_hold();
    int base;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      tests++;
      if (o_valid !== 1'b1 || o_data !== ACC_W'(150) || o_src !== 2'd1 || o_len !== 3'd2 || o_ren !== 3'b000) begin
        fails++;
        $display("FAIL hold_cycle%0d valid=%b data=%0d src=%0d len=%0d ren=%b exp 1/150/1/2/000",
                 i, o_valid, o_data, o_src, o_len, o_ren);
      end
    end
    base = res_n;
    i_ready = 1'b1;
    @(negedge i_clk);
    tests++; if (res_n !== base + 1 || o_valid !== 1'b0)
      begin fails++; $display("FAIL hold_accept accepted=%0d valid=%b exp 1/0", res_n - base, o_valid); end
  endtask

  task automatic test_max_value();
    int base;
    bit to;
    i_coef2 = 8'd255;
    base = res_n;
    for (int k = 0; k < 4; k++) push(2, 8'd255);
    wait_res(base + 1, to);
    tests++;
    if (to || res_data[base] !== ACC_W'(260100) || res_src[base] !== 2'd2 || res_len[base] !== 3'd4) begin
      fails++;
      $display("FAIL max_value timeout=%0d data=%0d src=%0d len=%0d exp 0/260100/2/4",
               to, res_data[base], res_src[base], res_len[base]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit to;
    i_coef0 = 8'd2; i_coef1 = 8'd5; i_coef2 = 8'd3;
    base = res_n;
    push(0, 8'd9);
    wait_res(base + 1, to);
    tests++; if (to || res_src[base] !== 2'd0 || res_data[base] !== ACC_W'(18))
      begin fails++; $display("FAIL rst_pre timeout=%0d src=%0d data=%0d exp 0/0/18", to, res_src[base], res_data[base]); end
    @(negedge i_clk);
    for (int k = 1; k <= 4; k++) push(1, 8'(k));
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b010) begin fails++; $display("FAIL rst_pop1 got=%b exp=010", o_ren); end
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b010) begin fails++; $display("FAIL rst_pop2 got=%b exp=010", o_ren); end
    i_rst = 1'b1;
    #1;
    tests++; if (o_ren !== 3'b000 || o_valid !== 1'b0 || o_busy !== 1'b0)
      begin fails++; $display("FAIL rst_abort ren=%b valid=%b busy=%b exp 000/0/0", o_ren, o_valid, o_busy); end
    push(0, 8'd9);
    push(2, 8'd7);
    @(negedge i_clk);
    i_rst = 1'b0;
    base = res_n;
    @(negedge i_clk);
    tests++; if (o_ren !== 3'b001) begin fails++; $display("FAIL rst_regrant got=%b exp=001", o_ren); end
    wait_res(base + 3, to);
    tests++;
    if (to || res_src[base] !== 2'd0 || res_data[base] !== ACC_W'(18) || res_len[base] !== 3'd1 ||
        res_src[base+1] !== 2'd1 || res_data[base+1] !== ACC_W'(45) || res_len[base+1] !== 3'd3 ||
        res_src[base+2] !== 2'd2 || res_data[base+2] !== ACC_W'(21) || res_len[base+2] !== 3'd1) begin
      fails++;
      $display("FAIL rst_after timeout=%0d got %0d/%0d/%0d %0d/%0d/%0d %0d/%0d/%0d exp 0/18/1 1/45/3 2/21/1", to,
               res_src[base], res_data[base], res_len[base], res_src[base+1], res_data[base+1], res_len[base+1],
               res_src[base+2], res_data[base+2], res_len[base+2]);
    end
  endtask

  task automatic test_coef_change();
    int base;
    bit to;
    i_coef0 = 8'd3;
    base = res_n;
    for (int k = 1; k <= 4; k++) push(0, 8'(k));
    repeat (2) @(negedge i_clk);
    i_coef0 = 8'd7;
    wait_res(base + 1, to);
    tests++; if (to || res_data[base] !== ACC_W'(30) || res_len[base] !== 3'd4)
      begin fails++; $display("FAIL coef_old timeout=%0d data=%0d len=%0d exp 0/30/4", to, res_data[base], res_len[base]); end
    for (int k = 1; k <= 4; k++) push(0, 8'(k));
    wait_res(base + 2, to);
    tests++; if (to || res_data[base+1] !== ACC_W'(70) || res_src[base+1] !== 2'd0)
      begin fails++; $display("FAIL coef_new timeout=%0d data=%0d src=%0d exp 0/70/0", to, res_data[base+1], res_src[base+1]); end
  endtask

  task automatic test_ren_protocol();
    tests++; if (ren_bad !== 0) begin fails++; $display("FAIL ren_protocol got=%0d bad cycles exp=0", ren_bad); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_hold();
    test_max_value();
    test_reset_mid();
    test_coef_change();
    test_ren_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_rr_sched.md
MAC_RR_SCHED -- requirements
Module: mac_rr_sched

Interface
REQ-001 SHALL have parameter DW, default 8, meaning width of each FIFO read word and coefficient.
REQ-002 SHALL have parameter BURST_MAX, default 4, meaning maximum words read per grant (range 1..7).
REQ-003 SHALL have parameter ACC_W, default 2*DW+3, meaning accumulator and result width.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous assert, active-high.
REQ-006 i_empty  input  3  per-source FIFO empty flag, bit n = source n, synchronous to i_clk.
REQ-007 i_rdata0, i_rdata1, i_rdata2  input  DW each  head-of-FIFO word (show-ahead), valid whenever the matching i_empty bit is 0.
REQ-008 o_ren  output  3  per-source FIFO read strobe; each high cycle pops one word.
REQ-009 i_coef0, i_coef1, i_coef2  input  DW each  per-source multiplier coefficient, quasi-static.
REQ-010 o_valid  output  1  result available.
REQ-011 i_ready  input  1  downstream accepts result.
REQ-012 o_data  output  ACC_W  burst result.
REQ-013 o_src  output  2  source index of the result (0..2).
REQ-014 o_len  output  3  number of words in the result (1..BURST_MAX).
REQ-015 o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM with states IDLE, READ and OUT.
REQ-017 IDLE: if any i_empty bit is 0, SHALL grant the first non-empty source after the last-served source in cyclic order 0->1->2->0, latch src, latch its coefficient into coef_q, clear acc and cnt, and go to READ; otherwise SHALL stay in IDLE.
REQ-018 READ: o_ren[src] SHALL equal (state==READ) & ~i_empty[src] & (cnt<BURST_MAX), combinationally; other o_ren bits SHALL be 0.
REQ-019 Each READ cycle with o_ren[src]=1 SHALL do acc <= acc + i_rdata[src]*coef_q (unsigned, full width, zero-extended to ACC_W) and cnt <= cnt+1.
REQ-020 READ SHALL exit to OUT on the cycle cnt reaches BURST_MAX or i_empty[src]=1 with cnt>=1; if i_empty[src]=1 with cnt==0, it SHALL return to IDLE with no output and no pointer update.
REQ-021 Back-to-back pops SHALL occur on consecutive cycles while the source stays non-empty; burst of N words takes N READ cycles.
REQ-022 OUT: o_valid=1 with o_data=acc, o_src=src, o_len=cnt, all held stable until i_ready=1.
REQ-023 OUT with i_ready=1 SHALL set last-served pointer to src and go to IDLE; o_valid SHALL drop the next cycle.
REQ-024 Latency: the first pop occurs 1 cycle after IDLE sees non-empty; o_valid rises the cycle after the last pop.
REQ-025 Coefficient changes during READ/OUT SHALL NOT affect the current burst.
REQ-026 No arithmetic overflow is possible: BURST_MAX*(2^DW-1)^2 fits ACC_W for the defaults; no wrap or saturation logic is required.
REQ-027 o_ren SHALL never assert in IDLE or OUT, and never for more than one source.

Reset
REQ-028 While i_rst=1: state=IDLE, o_ren=0, o_valid=0, o_data=0, o_src=0, o_len=0, o_busy=0, acc=0, cnt=0, last-served pointer=2 (source 0 served first).
REQ-029 Reset asserted mid-READ or mid-OUT SHALL abort the burst immediately; popped words are discarded and o_ren deasserts asynchronously.

Verification
REQ-030 All sources non-empty with 8 words each, coefs 1,2,3, i_ready=1 -> grants in order 0,1,2,0..., each o_len=4, o_data = sum(word*coef).
REQ-031 Source 1 holds 2 words {10,20}, coef=5, others empty -> 2 consecutive o_ren[1] pulses, then o_valid with o_data=150, o_src=1, o_len=2.
REQ-032 Result in OUT with i_ready=0 for 5 cycles -> o_valid, o_data, o_src and o_len stable, o_ren=0 throughout; accepted on the cycle i_ready=1.
REQ-033 Words 255, coef 255, 4-word burst -> o_data=260100, no overflow.
REQ-034 Assert i_rst during the 2nd pop of a burst -> o_ren=0 immediately, o_valid=0, next grant after release goes to source 0.
REQ-035 Coef changed from 3 to 7 during READ -> current burst uses 3, next burst from that source uses 7.
